// File: rtl/led_pkg.sv
// Shared definitions for the RGB LED PWM sequencer: mode encodings, colour
// and FSM enums, default timing for the 20 MHz fabric clock.
package led_pkg;

    localparam int PWM_BITS_DEF = 8;
    localparam int STEP_DIV_DEF = 78125;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_SOLID   = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_CYCLE   = 2'd3;

    typedef enum logic [1:0] {
        COL_R = 2'd0,
        COL_G = 2'd1,
        COL_B = 2'd2
    } colour_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SOLID     = 2'd1,
        ST_RAMP_UP   = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    function automatic colour_t next_colour(input colour_t c);
        case (c)
            COL_R:   next_colour = COL_G;
            COL_G:   next_colour = COL_B;
            default: next_colour = COL_R;
        endcase
    endfunction

    // One-hot channel select ordered {blue, green, red}.
    function automatic logic [2:0] colour_mask(input colour_t c);
        case (c)
            COL_G:   colour_mask = 3'b010;
            COL_B:   colour_mask = 3'b100;
            default: colour_mask = 3'b001;
        endcase
    endfunction

    // Entry state when leaving IDLE or restarting after a mode change.
    function automatic state_t start_state(input logic [1:0] m);
        case (m)
            MODE_SOLID:   start_state = ST_SOLID;
            MODE_BREATHE: start_state = ST_RAMP_UP;
            MODE_CYCLE:   start_state = ST_RAMP_UP;
            default:      start_state = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/led_pwm_sequencer_pwm_gen.sv
// PWM generator: free-running period counter, duty and channel select latched
// only at the period boundary, and a registered compare per channel.
module pwm_gen #(
    parameter int PWM_BITS = 8,
    parameter int CHANNELS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [CHANNELS-1:0] sel,
    output logic [CHANNELS-1:0] pwm
);

    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [PWM_BITS-1:0] ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [PWM_BITS-1:0] duty_applied_reg;
    logic [CHANNELS-1:0] sel_applied_reg;
    logic [CHANNELS-1:0] pwm_reg;
    logic [CHANNELS-1:0] pwm_next;
    logic                period_end;
    logic                active;

    assign period_end = (pwm_cnt_reg == MAX);
    assign active     = (pwm_cnt_reg < duty_applied_reg);

    // Colour is latched alongside duty so a colour switch never truncates a period.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign pwm_next[gi] = sel_applied_reg[gi] & active;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_reg      <= '0;
            duty_applied_reg <= '0;
            sel_applied_reg  <= '0;
            pwm_reg          <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + ONE;
            pwm_reg     <= pwm_next;
            if (period_end) begin
                duty_applied_reg <= duty;
                sel_applied_reg  <= sel;
            end
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: rtl/led_pwm_sequencer.sv
// RGB LED sequencer: step prescaler, mode FSM (off/solid/breathe/colour cycle)
// and colour routing into a single shared PWM generator.
module led_pwm_sequencer
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       redled,
    output logic       greenled,
    output logic       blueled,
    output logic       cycle_done
);

    localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(STEP_DIV - 1);
    localparam logic [PS_W-1:0]     PS_ONE  = {{(PS_W-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS-1:0] MAX     = '1;
    localparam logic [PWM_BITS-1:0] ONE     = {{(PWM_BITS-1){1'b0}}, 1'b1};

    logic [PS_W-1:0]     prescaler_reg;
    logic                step_tick;
    state_t              state_reg;
    colour_t             colour_reg;
    logic [PWM_BITS-1:0] duty_reg;
    logic [1:0]          mode_q_reg;
    logic                cycle_done_reg;
    logic [2:0]          pwm;
    logic                abort;
    logic                restart;

    assign step_tick = (prescaler_reg == PS_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_reg <= '0;
        end else if (step_tick) begin
            prescaler_reg <= '0;
        end else begin
            prescaler_reg <= prescaler_reg + PS_ONE;
        end
    end

    assign abort   = !en || (mode == MODE_OFF);
    assign restart = (mode != mode_q_reg) || (state_reg == ST_IDLE);

    // Abort and restart outrank step_tick, which also swallows cycle_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            colour_reg     <= COL_R;
            duty_reg       <= '0;
            mode_q_reg     <= MODE_OFF;
            cycle_done_reg <= 1'b0;
        end else begin
            mode_q_reg     <= mode;
            cycle_done_reg <= 1'b0;
            if (abort) begin
                state_reg  <= ST_IDLE;
                duty_reg   <= '0;
                colour_reg <= COL_R;
            end else if (restart) begin
                state_reg  <= start_state(mode);
                duty_reg   <= '0;
                colour_reg <= COL_R;
            end else begin
                case (state_reg)
                    ST_SOLID: begin
                        duty_reg   <= MAX;
                        colour_reg <= COL_R;
                    end
                    ST_RAMP_UP: begin
                        if (step_tick) begin
                            if (duty_reg == MAX) begin
                                state_reg <= ST_RAMP_DOWN;
                            end else begin
                                duty_reg <= duty_reg + ONE;
                            end
                        end
                    end
                    ST_RAMP_DOWN: begin
                        if (step_tick) begin
                            if (duty_reg <= ONE) begin
                                duty_reg       <= '0;
                                cycle_done_reg <= 1'b1;
                                state_reg      <= ST_RAMP_UP;
                                if (mode == MODE_CYCLE) begin
                                    colour_reg <= next_colour(colour_reg);
                                end
                            end else begin
                                duty_reg <= duty_reg - ONE;
                            end
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        duty_reg  <= '0;
                    end
                endcase
            end
        end
    end

    pwm_gen #(
        .PWM_BITS (PWM_BITS),
        .CHANNELS (3)
    ) u_pwm_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty_reg),
        .sel   (colour_mask(colour_reg)),
        .pwm   (pwm)
    );

    assign redled     = pwm[0];
    assign greenled   = pwm[1];
    assign blueled    = pwm[2];
    assign cycle_done = cycle_done_reg;

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Directed bench for led_pwm_sequencer at PWM_BITS=4, STEP_DIV=2 (MAX=15).
// Edge Rn is the n-th rising edge after reset release; samples are taken 1 ns after it.
module tb_led_pwm_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       redled;
    logic       greenled;
    logic       blueled;
    logic       cycle_done;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    logic [2:0] led_s  [0:255];
    logic       cd_s   [0:255];
    logic [3:0] duty_s [0:255];

    always #5 clk = ~clk;

    led_pwm_sequencer #(
        .PWM_BITS (4),
        .STEP_DIV (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .redled     (redled),
        .greenled   (greenled),
        .blueled    (blueled),
        .cycle_done (cycle_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_to(input int n);
        while (ecnt < n) begin
            @(posedge clk);
            #1;
            ecnt++;
            led_s[ecnt]  = {blueled, greenled, redled};
            cd_s[ecnt]   = cycle_done;
            duty_s[ecnt] = dut.duty_reg;
        end
    endtask

    function automatic int count_led(input int ch, input int lo, input int hi);
        int s = 0;
        for (int e = lo; e <= hi; e++) s += int'(led_s[e][ch]);
        return s;
    endfunction

    function automatic int count_all(input int lo, input int hi);
        return count_led(0, lo, hi) + count_led(1, lo, hi) + count_led(2, lo, hi);
    endfunction

    function automatic int count_cd(input int lo, input int hi);
        int s = 0;
        for (int e = lo; e <= hi; e++) s += int'(cd_s[e]);
        return s;
    endfunction

    task automatic do_reset(input logic en_v, input logic [1:0] mode_v);
        rst_n = 1'b0;
        en    = en_v;
        mode  = mode_v;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_leds", 32'({blueled, greenled, redled}), 32'd0);
            chk("rst_cycle_done", 32'(cycle_done), 32'd0);
        end
        rst_n = 1'b1;
        ecnt  = 0;
        $display("reset released en=%0d mode=%0d", en_v, mode_v);
    endtask

    initial begin
        // Colour cycle: cycle_done at R62, R124, R186 (31 steps x 2 clk each).
        do_reset(1'b1, 2'd3);
        run_to(224);
        chk("start_duty_R1", 32'(duty_s[1]), 32'd0);
        chk("start_duty_R2", 32'(duty_s[2]), 32'd1);
        chk("cyc_red_R49", 32'(count_led(0, 49, 64)), 32'd8);
        chk("cyc_grn_R49", 32'(count_led(1, 49, 64)), 32'd0);
        chk("cyc_grn_R81", 32'(count_led(1, 81, 96)), 32'd8);
        chk("cyc_red_R81", 32'(count_led(0, 81, 96)), 32'd0);
        chk("cyc_blu_R145", 32'(count_led(2, 145, 160)), 32'd9);
        chk("cyc_grn_R145", 32'(count_led(1, 145, 160)), 32'd0);
        chk("cyc_red_R209", 32'(count_led(0, 209, 224)), 32'd10);
        chk("cyc_gb_R209", 32'(count_led(1, 209, 224) + count_led(2, 209, 224)), 32'd0);
        chk("cyc_done_count", 32'(count_cd(1, 224)), 32'd3);
        chk("cyc_done_R186", 32'(cd_s[186]), 32'd1);
        $display("colour cycle segment done at edge %0d", ecnt);

        // Solid red: duty latched at R16 is 15, so periods from R17 carry 15 highs.
        do_reset(1'b1, 2'd1);
        run_to(48);
        chk("solid_p1_red", 32'(count_led(0, 1, 16)), 32'd0);
        chk("solid_p2_red", 32'(count_led(0, 17, 32)), 32'd15);
        chk("solid_p3_red", 32'(count_led(0, 33, 48)), 32'd15);
        chk("solid_gb", 32'(count_led(1, 1, 48) + count_led(2, 1, 48)), 32'd0);
        $display("solid segment done at edge %0d", ecnt);

        // Breathe red.
        do_reset(1'b1, 2'd2);
        run_to(130);
        chk("br_duty_R2", 32'(duty_s[2]), 32'd1);
        chk("br_duty_R30", 32'(duty_s[30]), 32'd15);
        chk("br_duty_R32", 32'(duty_s[32]), 32'd15);
        chk("br_duty_R34", 32'(duty_s[34]), 32'd14);
        chk("br_duty_R60", 32'(duty_s[60]), 32'd1);
        chk("br_duty_R62", 32'(duty_s[62]), 32'd0);
        chk("br_cd_R61", 32'(cd_s[61]), 32'd0);
        chk("br_cd_R62", 32'(cd_s[62]), 32'd1);
        chk("br_cd_R63", 32'(cd_s[63]), 32'd0);
        chk("br_cd_count", 32'(count_cd(1, 130)), 32'd2);
        chk("br_red_R17", 32'(count_led(0, 17, 32)), 32'd7);
        chk("br_red_R33", 32'(count_led(0, 33, 48)), 32'd15);
        chk("br_red_R49", 32'(count_led(0, 49, 64)), 32'd8);
        chk("br_gb", 32'(count_led(1, 1, 130) + count_led(2, 1, 130)), 32'd0);
        $display("breathe segment done at edge %0d", ecnt);

        // Abort mid-period: red at duty 8 is high R49..R56, en drops before R53.
        do_reset(1'b1, 2'd2);
        run_to(52);
        en = 1'b0;
        run_to(100);
        chk("ab_duty_R53", 32'(duty_s[53]), 32'd0);
        chk("ab_red_R49_56", 32'(count_led(0, 49, 56)), 32'd8);
        chk("ab_leds_off", 32'(count_all(57, 100)), 32'd0);
        chk("ab_no_cd", 32'(count_cd(53, 100)), 32'd0);
        en = 1'b1;
        run_to(128);
        chk("ab_re_duty_R101", 32'(duty_s[101]), 32'd0);
        chk("ab_re_duty_R102", 32'(duty_s[102]), 32'd1);
        chk("ab_re_red_R113", 32'(count_led(0, 113, 128)), 32'd5);
        chk("ab_re_gb", 32'(count_led(1, 101, 128) + count_led(2, 101, 128)), 32'd0);
        $display("abort segment done at edge %0d", ecnt);

        // Mode change 3->2 on green at duty 5 (after R72).
        do_reset(1'b1, 2'd3);
        run_to(72);
        chk("mc_duty_R72", 32'(duty_s[72]), 32'd5);
        mode = 2'd2;
        run_to(96);
        chk("mc_duty_R73", 32'(duty_s[73]), 32'd0);
        chk("mc_duty_R74", 32'(duty_s[74]), 32'd1);
        chk("mc_period_R65", 32'(count_all(65, 80)), 32'd0);
        chk("mc_red_R81", 32'(count_led(0, 81, 96)), 32'd3);
        chk("mc_gb_R81", 32'(count_led(1, 81, 96) + count_led(2, 81, 96)), 32'd0);
        $display("mode change segment done at edge %0d", ecnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
